// File: rtl/ts_sync_aligner_pkg.sv
// Shared constants and FSM encoding for the MPEG-TS sync aligner.
package ts_sync_aligner_pkg;

   localparam logic [7:0] TS_SYNC_BYTE = 8'h47;
   localparam int         TS_PKT_LEN   = 188;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      VERIFY = 2'd1,
      LOCK   = 2'd2
   } ts_state_e;

endpackage

// File: rtl/ts_sync_aligner.sv
// Byte-wide MPEG-TS synchroniser: hunts for 0x47, confirms packet spacing,
// then forwards only whole aligned packets with a packet-start strobe.
module ts_sync_aligner
   import ts_sync_aligner_pkg::*;
#(
   parameter int PKT_LEN    = TS_PKT_LEN,
   parameter int LOCK_CNT   = 3,
   parameter int UNLOCK_CNT = 3
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [7:0] DATA_IN,
   input  logic       DVALID_IN,
   output logic [7:0] DATA_OUT,
   output logic       DVALID_OUT,
   output logic       PSYNC_OUT,
   output logic       LOCKED,
   output logic [7:0] SYNC_LOSS_CNT
);

   localparam int               POS_W        = $clog2(PKT_LEN);
   localparam logic [POS_W-1:0] POS_LAST     = POS_W'(PKT_LEN - 1);
   localparam logic [POS_W-1:0] POS_ONE      = POS_W'(1);
   localparam logic [3:0]       LOCK_CNT_W   = 4'(LOCK_CNT);
   localparam logic [3:0]       UNLOCK_CNT_W = 4'(UNLOCK_CNT);

   ts_state_e        r_state;
   ts_state_e        w_state_nxt;
   logic [POS_W-1:0] r_pos;
   logic [POS_W-1:0] w_pos_nxt;
   logic [3:0]       r_good;
   logic [3:0]       w_good_nxt;
   logic [3:0]       r_miss;
   logic [3:0]       w_miss_nxt;
   logic             r_tei;
   logic             w_tei_nxt;

   logic             w_is_sync;
   logic             w_at_sync;
   logic [3:0]       w_good_inc;
   logic [3:0]       w_miss_inc;

   logic             w_fwd;
   logic             w_psync;
   logic [7:0]       w_data;
   logic             w_loss;

   logic [7:0]       r_data_out;
   logic             r_dvalid_out;
   logic             r_psync_out;
   logic             r_locked;
   logic [7:0]       r_loss_cnt;

   assign w_is_sync  = (DATA_IN == TS_SYNC_BYTE);
   assign w_at_sync  = (r_pos == '0);
   assign w_good_inc = r_good + 4'd1;
   assign w_miss_inc = r_miss + 4'd1;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state <= SEARCH;
         r_pos   <= '0;
         r_good  <= 4'd0;
         r_miss  <= 4'd0;
         r_tei   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pos   <= w_pos_nxt;
         r_good  <= w_good_nxt;
         r_miss  <= w_miss_nxt;
         r_tei   <= w_tei_nxt;
      end
   end

   // Next state and packet counters; everything holds while DVALID_IN is low.
   always_comb begin
      w_state_nxt = r_state;
      w_pos_nxt   = r_pos;
      w_good_nxt  = r_good;
      w_miss_nxt  = r_miss;
      w_tei_nxt   = r_tei;
      if (DVALID_IN) begin
         w_pos_nxt = (r_pos == POS_LAST) ? '0 : r_pos + POS_ONE;
         w_tei_nxt = 1'b0;
         case (r_state)
            SEARCH: begin
               if (w_is_sync) begin
                  w_pos_nxt  = POS_ONE;
                  w_good_nxt = 4'd1;
                  w_miss_nxt = 4'd0;
                  if (LOCK_CNT_W == 4'd1) begin
                     w_state_nxt = LOCK;
                  end else begin
                     w_state_nxt = VERIFY;
                  end
               end else begin
                  w_pos_nxt = '0;
               end
            end
            VERIFY: begin
               if (w_at_sync && w_is_sync) begin
                  w_good_nxt = w_good_inc;
                  if (w_good_inc == LOCK_CNT_W) begin
                     w_state_nxt = LOCK;
                     w_miss_nxt  = 4'd0;
                  end else begin
                     w_state_nxt = VERIFY;
                  end
               end else if (w_at_sync) begin
                  w_state_nxt = SEARCH;
                  w_pos_nxt   = '0;
                  w_good_nxt  = 4'd0;
                  w_miss_nxt  = 4'd0;
               end else begin
                  w_state_nxt = VERIFY;
               end
            end
            LOCK: begin
               if (w_at_sync && w_is_sync) begin
                  w_miss_nxt = 4'd0;
               end else if (w_at_sync && (w_miss_inc < UNLOCK_CNT_W)) begin
                  w_miss_nxt = w_miss_inc;
                  w_tei_nxt  = 1'b1;
               end else if (w_at_sync) begin
                  w_state_nxt = SEARCH;
                  w_pos_nxt   = '0;
                  w_good_nxt  = 4'd0;
                  w_miss_nxt  = 4'd0;
               end else begin
                  w_state_nxt = LOCK;
               end
            end
            default: begin
               w_state_nxt = SEARCH;
               w_pos_nxt   = '0;
               w_good_nxt  = 4'd0;
               w_miss_nxt  = 4'd0;
            end
         endcase
      end else begin
         w_tei_nxt = r_tei;
      end
   end

   // Forwarding decision: a repaired sync gets 0x47, the byte after it gets TEI.
   always_comb begin
      w_fwd   = 1'b0;
      w_psync = 1'b0;
      w_data  = DATA_IN;
      w_loss  = 1'b0;
      if (DVALID_IN) begin
         case (r_state)
            SEARCH: begin
               if (w_is_sync && (LOCK_CNT_W == 4'd1)) begin
                  w_fwd   = 1'b1;
                  w_psync = 1'b1;
               end else begin
                  w_fwd = 1'b0;
               end
            end
            VERIFY: begin
               if (w_at_sync && w_is_sync && (w_good_inc == LOCK_CNT_W)) begin
                  w_fwd   = 1'b1;
                  w_psync = 1'b1;
               end else begin
                  w_fwd = 1'b0;
               end
            end
            LOCK: begin
               w_fwd = 1'b1;
               if (w_at_sync && w_is_sync) begin
                  w_psync = 1'b1;
               end else if (w_at_sync && (w_miss_inc < UNLOCK_CNT_W)) begin
                  w_psync = 1'b1;
                  w_data  = TS_SYNC_BYTE;
               end else if (w_at_sync) begin
                  w_fwd  = 1'b0;
                  w_loss = 1'b1;
               end else if (r_tei) begin
                  w_data = DATA_IN | 8'h80;
               end else begin
                  w_data = DATA_IN;
               end
            end
            default: begin
               w_fwd = 1'b0;
            end
         endcase
      end else begin
         w_fwd = 1'b0;
      end
   end

   // One-cycle registered output stage.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_data_out   <= 8'h00;
         r_dvalid_out <= 1'b0;
         r_psync_out  <= 1'b0;
         r_locked     <= 1'b0;
         r_loss_cnt   <= 8'h00;
      end else begin
         r_dvalid_out <= w_fwd;
         r_psync_out  <= w_psync;
         r_locked     <= (w_state_nxt == LOCK);
         if (w_fwd) begin
            r_data_out <= w_data;
         end
         if (w_loss && (r_loss_cnt != 8'hFF)) begin
            r_loss_cnt <= r_loss_cnt + 8'd1;
         end
      end
   end

   assign DATA_OUT      = r_data_out;
   assign DVALID_OUT    = r_dvalid_out;
   assign PSYNC_OUT     = r_psync_out;
   assign LOCKED        = r_locked;
   assign SYNC_LOSS_CNT = r_loss_cnt;

endmodule

// File: tb/tb_ts_sync_aligner.sv
// Directed scenarios with random payload, checked against a packet-level
// reference model that scans the whole input stream for the expected output.
module tb_ts_sync_aligner;

   localparam int PL   = 188;
   localparam int LCNT = 3;
   localparam int UCNT = 3;

   logic       CLK;
   logic       RST;
   logic [7:0] DATA_IN;
   logic       DVALID_IN;
   logic [7:0] DATA_OUT;
   logic       DVALID_OUT;
   logic       PSYNC_OUT;
   logic       LOCKED;
   logic [7:0] SYNC_LOSS_CNT;

   int total = 0;
   int bad   = 0;
   int n_out;
   int first_out;

   logic [7:0] s_q[$];
   logic [7:0] tmp_q[$];
   bit         e_fwd[];
   bit         e_ps[];
   bit         e_lk[];
   logic [7:0] e_dat[];
   int         e_loss[];

   ts_sync_aligner #(.PKT_LEN(PL), .LOCK_CNT(LCNT), .UNLOCK_CNT(UCNT)) dut (
      .CLK           (CLK),
      .RST           (RST),
      .DATA_IN       (DATA_IN),
      .DVALID_IN     (DVALID_IN),
      .DATA_OUT      (DATA_OUT),
      .DVALID_OUT    (DVALID_OUT),
      .PSYNC_OUT     (PSYNC_OUT),
      .LOCKED        (LOCKED),
      .SYNC_LOSS_CNT (SYNC_LOSS_CNT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   function automatic logic [7:0] rnd_payload();
      logic [7:0] b;
      b = 8'($urandom_range(0, 255));
      if (b == 8'h47) b = 8'h46;
      return b;
   endfunction

   task automatic add_pkt(input logic [7:0] sb);
      s_q.push_back(sb);
      for (int k = 1; k < PL; k++) s_q.push_back(rnd_payload());
   endtask

   // Packet-level scan: find a sync, hop by PL to confirm, then emit whole packets.
   task automatic run_model();
      int n, i, j, p, good, miss, run;
      bit ok;
      int ev[];
      n = s_q.size();
      e_fwd = new[n]; e_ps = new[n]; e_lk = new[n]; e_dat = new[n]; e_loss = new[n];
      ev = new[n];
      for (int k = 0; k < n; k++) begin
         e_fwd[k] = 1'b0; e_ps[k] = 1'b0; e_lk[k] = 1'b0; e_dat[k] = 8'h00; ev[k] = 0;
      end
      i = 0;
      while (i < n) begin
         if (s_q[i] != 8'h47) begin
            i++;
         end else begin
            j = i; good = 1; ok = 1'b0;
            while (1) begin
               if (good >= LCNT) begin ok = 1'b1; break; end
               j += PL;
               if (j >= n) break;
               if (s_q[j] != 8'h47) break;
               good++;
            end
            if (!ok) begin
               i = j + 1;
            end else begin
               p = j; miss = 0;
               while (p < n) begin
                  if (s_q[p] == 8'h47) miss = 0; else miss++;
                  if (miss >= UCNT) begin ev[p] = 1; break; end
                  for (int b = 0; b < PL && p + b < n; b++) begin
                     e_fwd[p+b] = 1'b1; e_lk[p+b] = 1'b1; e_dat[p+b] = s_q[p+b];
                  end
                  e_ps[p] = 1'b1; e_dat[p] = 8'h47;
                  if (miss > 0 && p + 1 < n) e_dat[p+1] = s_q[p+1] | 8'h80;
                  p += PL;
               end
               i = p + 1;
            end
         end
      end
      run = 0;
      for (int k = 0; k < n; k++) begin
         if (ev[k] != 0 && run < 255) run++;
         e_loss[k] = run;
      end
   endtask

   task automatic drive(input int gap, input int last);
      n_out = 0; first_out = -1;
      for (int idx = 0; idx < last; idx++) begin
         for (int g = 0; g < gap; g++) begin
            @(negedge CLK); DVALID_IN = 1'b0; DATA_IN = 8'($urandom_range(0, 255));
            @(posedge CLK); #1;
            chk("gap_dvalid", DVALID_OUT, 32'd0);
         end
         @(negedge CLK); DATA_IN = s_q[idx]; DVALID_IN = 1'b1;
         @(posedge CLK); #1;
         chk("dvalid", DVALID_OUT, e_fwd[idx]);
         if (e_fwd[idx]) begin
            chk("data", DATA_OUT, e_dat[idx]);
            chk("psync", PSYNC_OUT, e_ps[idx]);
            n_out++;
            if (first_out < 0) first_out = idx;
         end
         chk("locked", LOCKED, e_lk[idx]);
         chk("loss_cnt", SYNC_LOSS_CNT, e_loss[idx]);
      end
   endtask

   task automatic do_reset();
      DVALID_IN = 1'b0;
      RST = 1'b0;
      repeat (2) @(negedge CLK);
      RST = 1'b1;
   endtask

   initial begin
      RST = 1'b0; DVALID_IN = 1'b0; DATA_IN = 8'h00;
      repeat (3) @(negedge CLK);
      chk("rst_dvalid", DVALID_OUT, 32'd0);
      chk("rst_psync", PSYNC_OUT, 32'd0);
      chk("rst_data", DATA_OUT, 32'd0);
      chk("rst_locked", LOCKED, 32'd0);
      chk("rst_loss", SYNC_LOSS_CNT, 32'd0);
      RST = 1'b1;

      // Clean stream: packets 3-5 come out.
      s_q.delete();
      for (int k = 0; k < 5; k++) add_pkt(8'h47);
      run_model();
      drive(0, s_q.size());
      chk("clean_nout", n_out, 3 * PL);
      chk("clean_first", first_out, 2 * PL);

      // False sync at offset 50, true packets from offset 100.
      do_reset();
      s_q.delete();
      for (int k = 0; k < 100; k++) s_q.push_back(rnd_payload());
      s_q[50] = 8'h47;
      for (int k = 0; k < 6; k++) add_pkt(8'h47);
      run_model();
      drive(0, s_q.size());
      chk("false_first", first_out, 100 + 3 * PL);
      chk("false_nout", n_out, 3 * PL);

      // Single corrupt sync on packet 7.
      do_reset();
      s_q.delete();
      for (int k = 0; k < 10; k++) add_pkt((k == 6) ? 8'h00 : 8'h47);
      run_model();
      drive(0, s_q.size());
      chk("single_first", first_out, 2 * PL);
      chk("single_nout", n_out, 8 * PL);
      chk("single_locked_end", LOCKED, 32'd1);
      chk("single_loss_end", SYNC_LOSS_CNT, 32'd0);

      // Three corrupt syncs (packets 7-9), relock, then reset at byte 100 of packet 15.
      do_reset();
      s_q.delete();
      for (int k = 0; k < 16; k++) add_pkt((k >= 6 && k <= 8) ? 8'h00 : 8'h47);
      run_model();
      drive(0, 14 * PL + 101);
      chk("triple_nout", n_out, 6 * PL + 3 * PL + 101);
      chk("pre_rst_loss", SYNC_LOSS_CNT, 32'd1);
      chk("pre_rst_dvalid", DVALID_OUT, 32'd1);
      chk("pre_rst_locked", LOCKED, 32'd1);
      RST = 1'b0;
      #1;
      chk("async_rst_dvalid", DVALID_OUT, 32'd0);
      chk("async_rst_locked", LOCKED, 32'd0);
      chk("async_rst_loss", SYNC_LOSS_CNT, 32'd0);
      DVALID_IN = 1'b0;
      repeat (2) @(negedge CLK);
      RST = 1'b1;
      tmp_q = s_q[14*PL+101 : 15*PL-1];
      s_q = tmp_q;
      for (int k = 0; k < 4; k++) add_pkt(8'h47);
      run_model();
      drive(0, s_q.size());
      chk("post_rst_first", first_out, 87 + 2 * PL);
      chk("post_rst_nout", n_out, 2 * PL);

      // Gapped input, one valid in three cycles.
      do_reset();
      s_q.delete();
      for (int k = 0; k < 5; k++) add_pkt(8'h47);
      run_model();
      drive(2, s_q.size());
      chk("gap_nout", n_out, 3 * PL);
      chk("gap_first", first_out, 2 * PL);
      DVALID_IN = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
